hb_task_queue_subsystem: RTL and testbench
==========================================

// Module: hb_task_queue_subsystem
// PURPOSE
//  Task-dispatch front end: a 32-bit task FIFO (queue core) feeding two observers, a
//  one-stage distributor register and a 4-bank round-robin arbiter. The host pushes and
//  pops the FIFO directly. The distributor and arbiter snoop the FIFO head and do not pop it.
//  Their outputs are exported as observability ports.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  DATA_W  32  task word width; bank field is data[1:0]
// PORTS
//  clk              in   1       single clock; all state updates on posedge
//  reset            in   1       synchronous, active-high
//  push_req         in   1       enqueue data_in this cycle
//  data_in          in   DATA_W  task word to enqueue
//  pop_req          in   1       dequeue head this cycle
//  full             out  1       FIFO holds DEPTH entries
//  valid_out        out  1       FIFO non-empty; data_out valid
//  data_out         out  DATA_W  FIFO head (show-ahead)
//  dist_out_valid   out  1       distributor output valid
//  dist_out_data    out  DATA_W  distributor output word
//  arb_grant_out    out  2       bank granted in the most recent arbitration
//  arb_served_bank  out  2       bank granted one arbitration earlier (service completed)
// BEHAVIOUR
//  Queue core:
//  - Circular buffer with rd_ptr/wr_ptr (log2 DEPTH bits, natural wrap) and count (log2 DEPTH+1 bits).
//  - full = (count==DEPTH); valid_out = (count!=0); data_out = mem[rd_ptr], combinational.
//  - push accepted iff push_req && !full; pop accepted iff pop_req && valid_out.
//  - full and valid_out are computed from count before this cycle's update.
//  - Push when full: dropped, no state change. This holds even with a simultaneous pop.
//  - Pop when empty: ignored. Push+pop while empty: only the push takes effect.
//  - Push+pop while 0<count<DEPTH: both take effect and count is unchanged.
//  - Pushed data is visible on data_out the cycle after the push when the FIFO was empty.
//  Distributor (consumer_ready tied 1 internally):
//  - out_valid/out_data register in_valid/in_data every cycle, so latency is 1 cycle.
//  - Internally, when consumer_ready=0 the output holds while out_valid=1.
//  - A new input is captured only when !out_valid || consumer_ready.
//  Arbiter (4 banks):
//  - pending[3:0] register.
//  - Each cycle, the request mask is pending | (in_valid ? onehot(in_data[1:0]) : 0).
//  - If the mask is non-zero: select the first set bit searching from last_grant+1, mod 4.
//  - Then grant_out <= selected, served_bank <= old grant_out, last_grant <= selected,
//    and pending <= mask with the selected bit cleared.
//  - If the mask is zero: all arbiter registers hold.
//  - A persistent head re-requests its bank every cycle it stays valid; this is intended.
//  Reset:
//  - Pointers, count, pending, grant_out and served_bank clear to 0; last_grant resets to 3,
//    so bank 0 is searched first.
//  - dist_out_valid=0 and dist_out_data=0.
//  - Outputs after reset: full=0, valid_out=0, data_out undefined (bench must not check it).
//  - FIFO memory is not cleared.
//  - Reset asserted mid-operation discards all entries and pending requests on that edge.
// TESTING
//  - Reset, then push 0xA0,0xA1,0xA2 on consecutive cycles -> valid_out=1 the cycle after
//    the first push; data_out=0xA0. Pop 3 times -> 0xA0,0xA1,0xA2 in order, then valid_out=0.
//  - Push 16 words -> full=1. 17th push dropped. Pop 16 -> original order, full=0 after the
//    first pop, and the 17th word is never seen.
//  - Wrap: push 12, pop 12, push 16 -> data order preserved across pointer wrap; full=1.
//  - Push 0x5 (empty) with pop_req held high -> queue gets 1 entry.
//    dist_out_valid=1 / dist_out_data=0x5 one cycle after valid_out rises.
//  - Push 0x2 then 0x1 with no pop, hold 0x2 at head -> arb_grant_out=2 first cycle.
//    Pop, head 0x1 -> grant 1, served_bank=2. Empty queue -> grant/served hold.
//  - Assert reset with 5 entries queued -> next cycle valid_out=0, full=0,
//    arb_grant_out=0, dist_out_valid=0.

Source files
------------

// File: rtl/hb_task_queue_subsystem.sv
`default_nettype none
// ============================================================================
//  Module      : hb_task_queue_subsystem
//  Description : Task-dispatch front end. A circular task FIFO that the host
//                pushes and pops directly, plus two observers that snoop the
//                FIFO head without popping it:
//                  - a one-stage distributor register (consumer always ready)
//                  - a 4-bank round-robin arbiter keyed on head bits [1:0]
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                push_req, data_in   - enqueue request and task word
//                pop_req             - dequeue request
//                full, valid_out     - FIFO status
//                data_out            - FIFO head (show-ahead)
//                dist_out_valid/data - distributor register outputs
//                arb_grant_out       - bank granted in the latest arbitration
//                arb_served_bank     - bank granted one arbitration earlier
//  Revision    : 1.0 - initial release
// ============================================================================
module hb_task_queue_subsystem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_req,
    output logic              full,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              dist_out_valid,
    output logic [DATA_W-1:0] dist_out_data,
    output logic [1:0]        arb_grant_out,
    output logic [1:0]        arb_served_bank
);

    localparam int             AW           = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  C_PTR_ONE    = AW'(1);
    localparam logic [AW:0]    C_CNT_ONE    = (AW+1)'(1);

    // ------------------------------------------------------------------
    // Queue core
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_count == C_FULL_COUNT);
    assign valid_out = (r_count != '0);
    assign data_out  = r_mem[r_rd_ptr];

    // Status comes from the pre-update count, so a push into a full queue is
    // dropped even when a pop frees a slot in the same cycle.
    assign w_push_ok = push_req && !full;
    assign w_pop_ok  = pop_req  && valid_out;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Distributor: single register stage fed by the FIFO head
    // ------------------------------------------------------------------
    logic              w_consumer_ready;
    logic              r_dist_valid;
    logic [DATA_W-1:0] r_dist_data;

    assign w_consumer_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dist_valid <= 1'b0;
            r_dist_data  <= '0;
        end else if (!r_dist_valid || w_consumer_ready) begin
            r_dist_valid <= valid_out;
            r_dist_data  <= data_out;
        end
    end

    assign dist_out_valid = r_dist_valid;
    assign dist_out_data  = r_dist_data;

    // ------------------------------------------------------------------
    // Round-robin arbiter over 4 banks
    // ------------------------------------------------------------------
    logic [3:0] r_pending;
    logic [1:0] r_grant;
    logic [1:0] r_served;
    logic [1:0] r_last_grant;
    logic [3:0] w_head_req;
    logic [3:0] w_req_mask;
    logic [1:0] w_start;
    logic [7:0] w_mask_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_ofs;
    logic [1:0] w_sel;

    assign w_head_req = valid_out ? (4'b0001 << data_out[1:0]) : 4'b0000;
    assign w_req_mask = r_pending | w_head_req;

    // Rotate the mask so the search start lands at bit 0, pick the lowest
    // set bit, then rotate the index back by adding the start offset.
    assign w_start    = r_last_grant + 2'd1;
    assign w_mask_dbl = {w_req_mask, w_req_mask} >> w_start;
    assign w_rot      = w_mask_dbl[3:0];

    always_comb begin
        w_ofs = 2'd3;
        if (w_rot[0]) begin
            w_ofs = 2'd0;
        end else if (w_rot[1]) begin
            w_ofs = 2'd1;
        end else if (w_rot[2]) begin
            w_ofs = 2'd2;
        end
    end

    assign w_sel = w_start + w_ofs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= 4'b0000;
            r_grant      <= 2'd0;
            r_served     <= 2'd0;
            r_last_grant <= 2'd3;   // bank 0 is searched first after reset
        end else if (w_req_mask != 4'b0000) begin
            r_grant      <= w_sel;
            r_served     <= r_grant;
            r_last_grant <= w_sel;
            r_pending    <= w_req_mask & ~(4'b0001 << w_sel);
        end
    end

    assign arb_grant_out   = r_grant;
    assign arb_served_bank = r_served;

endmodule
`default_nettype wire

// File: tb/tb_hb_task_queue_subsystem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hb_task_queue_subsystem
//  Description : Self-checking bench for hb_task_queue_subsystem. Directed
//                scenarios followed by randomized traffic, all compared
//                cycle by cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hb_task_queue_subsystem;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              push_req;
    logic [DATA_W-1:0] data_in;
    logic              pop_req;
    logic              full;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              dist_out_valid;
    logic [DATA_W-1:0] dist_out_data;
    logic [1:0]        arb_grant_out;
    logic [1:0]        arb_served_bank;

    hb_task_queue_subsystem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .push_req        (push_req),
        .data_in         (data_in),
        .pop_req         (pop_req),
        .full            (full),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .dist_out_valid  (dist_out_valid),
        .dist_out_data   (dist_out_data),
        .arb_grant_out   (arb_grant_out),
        .arb_served_bank (arb_served_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    bit          m_pend[4];
    int          m_grant;
    int          m_served;
    int          m_last;
    bit          m_dist_v;
    logic [31:0] m_dist_d;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_grant  = 0;
        m_served = 0;
        m_last   = 3;
        m_dist_v = 0;
        m_dist_d = 32'h0;
    endtask

    task automatic model_step(input bit p, input logic [31:0] d, input bit pp, input bit r);
        bit          vo;
        bit          fl;
        logic [31:0] head;
        bit          req[4];
        bit          any;
        int          sel;
        if (r) begin
            model_reset();
            return;
        end
        vo   = (m_q.size() != 0);
        fl   = (m_q.size() == DEPTH);
        head = vo ? m_q[0] : 32'h0;
        // distributor
        m_dist_v = vo;
        m_dist_d = head;
        // arbiter: requests are pending banks plus the bank of a valid head
        any = 0;
        for (int b = 0; b < 4; b++) begin
            req[b] = m_pend[b] || (vo && (int'(head[1:0]) == b));
            if (req[b]) any = 1;
        end
        if (any) begin
            sel = -1;
            for (int k = 1; k <= 4; k++) begin
                if (sel < 0 && req[(m_last + k) % 4]) sel = (m_last + k) % 4;
            end
            m_served = m_grant;
            m_grant  = sel;
            m_last   = sel;
            for (int b = 0; b < 4; b++) m_pend[b] = req[b] && (b != sel);
        end
        // queue
        if (pp && vo) void'(m_q.pop_front());
        if (p && !fl) m_q.push_back(d);
    endtask

    task automatic compare_all();
        check_eq("full", full, (m_q.size() == DEPTH));
        check_eq("valid_out", valid_out, (m_q.size() != 0));
        if (m_q.size() != 0) check_eq("data_out", data_out, m_q[0]);
        check_eq("dist_valid", dist_out_valid, m_dist_v);
        if (m_dist_v) check_eq("dist_data", dist_out_data, m_dist_d);
        check_eq("arb_grant", arb_grant_out, m_grant);
        check_eq("arb_served", arb_served_bank, m_served);
    endtask

    // One clock: drive inputs, compare registered state mid-cycle, advance model.
    task automatic do_cycle(input bit p, input logic [31:0] d, input bit pp, input bit r);
        push_req = p;
        data_in  = d;
        pop_req  = pp;
        reset    = r;
        @(negedge clk);
        compare_all();
        model_step(p, d, pp, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 32'h0, 0, 0);
    endtask

    initial begin
        push_req = 0;
        data_in  = '0;
        pop_req  = 0;
        reset    = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 0;
        check_eq("rst_full", full, 0);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_dist_valid", dist_out_valid, 0);
        check_eq("rst_grant", arb_grant_out, 0);

        // Three pushes, then three pops in order
        do_cycle(1, 32'hA0, 0, 0);
        check_eq("t1_valid_after_push", valid_out, 1);
        check_eq("t1_head", data_out, 32'hA0);
        do_cycle(1, 32'hA1, 0, 0);
        do_cycle(1, 32'hA2, 0, 0);
        do_cycle(0, 32'h0, 1, 0);
        check_eq("t1_pop1_head", data_out, 32'hA1);
        do_cycle(0, 32'h0, 1, 0);
        check_eq("t1_pop2_head", data_out, 32'hA2);
        do_cycle(0, 32'h0, 1, 0);
        check_eq("t1_empty", valid_out, 0);
        idle(2);

        // Fill, overflow drop, drain
        for (int i = 0; i < DEPTH; i++) do_cycle(1, 32'h100 + i, 0, 0);
        check_eq("t2_full", full, 1);
        do_cycle(1, 32'hDEAD, 0, 0);
        check_eq("t2_still_full", full, 1);
        do_cycle(1, 32'hBEEF, 1, 0);     // full + pop: push still dropped
        check_eq("t2_full_clear", full, 0);
        check_eq("t2_head_after_pop", data_out, 32'h101);
        for (int i = 1; i < DEPTH; i++) do_cycle(0, 32'h0, 1, 0);
        check_eq("t2_drained", valid_out, 0);
        idle(2);

        // Wrap: push 12, pop 12, push 16
        for (int i = 0; i < 12; i++) do_cycle(1, 32'h200 + i, 0, 0);
        for (int i = 0; i < 12; i++) do_cycle(0, 32'h0, 1, 0);
        for (int i = 0; i < DEPTH; i++) do_cycle(1, 32'h300 + i, 0, 0);
        check_eq("t3_full", full, 1);
        check_eq("t3_head", data_out, 32'h300);
        for (int i = 0; i < DEPTH; i++) do_cycle(0, 32'h0, 1, 0);
        idle(2);

        // Push+pop while empty: push only
        do_cycle(1, 32'h5, 1, 0);
        check_eq("t4_one_entry", valid_out, 1);
        do_cycle(0, 32'h0, 0, 0);
        check_eq("t4_dist_valid", dist_out_valid, 1);
        check_eq("t4_dist_data", dist_out_data, 32'h5);
        do_cycle(0, 32'h0, 1, 0);
        idle(2);

        // Arbiter sequence (reset first so last_grant is known)
        do_cycle(0, 32'h0, 0, 1);
        do_cycle(1, 32'h2, 0, 0);
        do_cycle(1, 32'h1, 0, 0);
        check_eq("t5_grant_2", arb_grant_out, 2);
        do_cycle(0, 32'h0, 1, 0);
        do_cycle(0, 32'h0, 0, 0);
        check_eq("t5_grant_1", arb_grant_out, 1);
        check_eq("t5_served_2", arb_served_bank, 2);
        do_cycle(0, 32'h0, 1, 0);
        idle(3);

        // Reset mid-operation with 5 entries
        for (int i = 0; i < 5; i++) do_cycle(1, 32'h400 + i, 0, 0);
        do_cycle(0, 32'h0, 0, 1);
        check_eq("t6_valid", valid_out, 0);
        check_eq("t6_full", full, 0);
        check_eq("t6_grant", arb_grant_out, 0);
        check_eq("t6_dist_valid", dist_out_valid, 0);

        // Randomized traffic with varying push/pop bias and rare resets
        for (int ph = 0; ph < 6; ph++) begin
            int push_pct;
            int pop_pct;
            push_pct = (ph % 2 == 0) ? 80 : 30;
            pop_pct  = (ph % 2 == 0) ? 25 : 75;
            for (int i = 0; i < 150; i++) begin
                bit p;
                bit pp;
                bit r;
                p  = ($urandom_range(99) < push_pct);
                pp = ($urandom_range(99) < pop_pct);
                r  = ($urandom_range(199) == 0);
                do_cycle(p, $urandom, pp, r);
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
